mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage initiator for the word-addressed data memory. It accepts load/store requests
//  from the pipeline, drives a req/ack handshake toward a variable-latency memory and
//  freezes the pipeline until the access completes. Each access has a bounded wait
//  (timeout). The block sits between the EXE/MEM pipeline register and the memory port.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in BUSY without m_ack before abort (1..65535)
//  TO_W            16   width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  mem_read     in   1   pipeline load request
//  mem_write    in   1   pipeline store request (wins if both asserted)
//  address      in   32  byte address from the ALU
//  data         in   32  store data
//  mem_result   out  32  load data to MEM/WB; valid only in DONE
//  freeze       out  1   stall pipeline (hold PC and all stage registers)
//  done         out  1   one-cycle pulse: access complete
//  err          out  1   sticky error (timeout, or misalignment when enabled)
//  m_req        out  1   memory request; held high until m_ack or timeout
//  m_we         out  1   1 = write, 0 = read; stable while m_req is high
//  m_addr       out  32  byte address; stable while m_req is high
//  m_wdata      out  32  write data; stable while m_req is high
//  m_rdata      in   32  read data; valid in the m_ack cycle
//  m_ack        in   1   memory completion; one cycle; ignored outside BUSY
// BEHAVIOUR
//  - Interface: one clock clk; reset rst is synchronous and active-high.
//  - Reset: state=IDLE. m_req, m_we, done, err = 0. m_addr, m_wdata, rdata_q and
//    timeout counter = 0. freeze is forced to 0 while rst=1. Reset mid-access abandons
//    the access. m_req drops on the next edge. A late m_ack is then ignored.
//  - States: IDLE, BUSY, DONE (2-bit encoding).
//  - IDLE: if mem_read|mem_write, then freeze=1 combinationally in the same cycle. Register
//    address, data and we=mem_write into m_addr, m_wdata and m_we. Set m_req=1, clear the
//    counter and go to BUSY. With no request, freeze=0 and stay in IDLE.
//  - BUSY: freeze=1 and the counter increments each cycle.
//    - On m_ack: capture m_rdata into rdata_q (reads only), drop m_req and go to DONE.
//    - When the counter reaches TIMEOUT_CYCLES-1 without m_ack: drop m_req, set err,
//      rdata_q=0, go to DONE.
//    - m_ack in the same cycle as the timeout: m_ack wins and err is not set.
//  - DONE: one cycle. freeze=0 and done=1. mem_result=rdata_q for a read, 0 for a write.
//    The pipeline advances at this edge. Inputs are ignored in this cycle. Next state
//    is IDLE.
//  - Outside DONE, mem_result=0 and done=0.
//  - Minimum latency: request seen in cycle 0, m_req high in cycle 1, m_ack in cycle 1,
//    DONE in cycle 2. The freeze duration is 2 cycles plus the memory wait.
//  - A request can only be accepted in IDLE. Back-to-back accesses therefore have one
//    IDLE cycle between them.
//  - err is sticky until rst.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - An IDLE request with address[1:0]!=0 issues no m_req.
//    - It goes IDLE->DONE directly, with freeze=1 for that one cycle.
//    - It sets err and gives mem_result=0.
//  MEM_ALIGN_CHECK_EN undefined:
//    - address is forwarded unchanged.
//    - Memory performs word alignment by dropping bits [1:0].
// STRUCTURE
//  - Shared package mem_ctrl_pkg: state encodings (ST_IDLE=0, ST_BUSY=1, ST_DONE=2) and
//    the default TIMEOUT_CYCLES constant.
//  - Sub-module mem_timeout_ctr (clear, enable, expire output at TIMEOUT_CYCLES-1),
//    instantiated once.
//  - Everything else is in this module: FSM, request holding registers, read capture.
// TESTING
//  1 Read, ack 1 cycle after m_req: addr=0x10, m_rdata=0xDEADBEEF -> m_req high for 1
//    cycle, m_we=0, m_addr=0x10; DONE has mem_result=0xDEADBEEF, done=1; freeze high 2 cycles.
//  2 Write with 5-cycle wait: addr=0x20, data=0x12345678 -> m_we=1, m_wdata stable for 5
//    cycles; DONE has mem_result=0, err=0.
//  3 Timeout: TIMEOUT_CYCLES=8, never ack -> m_req drops after 8 BUSY cycles, err=1,
//    mem_result=0; a later m_ack is ignored and the state is IDLE.
//  4 rst asserted in BUSY cycle 3 -> next edge IDLE, m_req=0, freeze=0, err=0; m_ack on
//    the following cycle causes no done pulse.
//  5 mem_read=mem_write=1, addr=0x4 -> write issued (m_we=1); ack on the timeout cycle ->
//    err stays 0.
//  6 With MEM_ALIGN_CHECK_EN, read addr=0x6 -> no m_req, DONE next cycle, err=1. Without
//    the macro: m_addr=0x6 is issued normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and default timeout for the MEM-stage memory controller.
package mem_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: wait counter for one memory access; expire flags the last allowed BUSY cycle.
module mem_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   logic [TO_W-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clear) cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   assign expire = cnt == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage req/ack initiator with pipeline freeze and bounded wait.
// Define MEM_ALIGN_CHECK_EN to reject misaligned addresses instead of forwarding them.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int TO_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] data,
   output logic [31:0] mem_result,
   output logic        freeze,
   output logic        done,
   output logic        err,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack
);
`ifdef MEM_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif
   state_t state;
   logic [31:0] rdata_q;
   logic expire;
   logic req;
   logic misaligned;
   assign req = mem_read | mem_write;
   assign misaligned = ALIGN_EN && address[1:0] != 2'b00;
   assign freeze = !rst && (state == ST_BUSY || (state == ST_IDLE && req));
   assign done = state == ST_DONE;
   assign mem_result = done ? rdata_q : '0;
   mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_ctr (
      .clk(clk),
      .rst(rst),
      .clear(state != ST_BUSY),
      .enable(state == ST_BUSY),
      .expire(expire)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         m_req <= 1'b0;
         m_we <= 1'b0;
         err <= 1'b0;
         m_addr <= '0;
         m_wdata <= '0;
         rdata_q <= '0;
      end else
         case (state)
            ST_IDLE:
               if (req && misaligned) begin
                  err <= 1'b1;
                  rdata_q <= '0;
                  state <= ST_DONE;
               end else if (req) begin
                  m_addr <= address;
                  m_wdata <= data;
                  m_we <= mem_write;
                  m_req <= 1'b1;
                  state <= ST_BUSY;
               end
            ST_BUSY:
               // ack takes priority over a timeout landing in the same cycle
               if (m_ack) begin
                  rdata_q <= m_we ? '0 : m_rdata;
                  m_req <= 1'b0;
                  state <= ST_DONE;
               end else if (expire) begin
                  rdata_q <= '0;
                  err <= 1'b1;
                  m_req <= 1'b0;
                  state <= ST_DONE;
               end
            default: state <= ST_IDLE;
         endcase
endmodule
